// File: rtl/serial_word_tx_pkg.sv
// Shared definitions for the serial word transmitter: FSM state encoding
// and the default word width.
package serial_word_tx_pkg;

    localparam int W_DEF = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Counter width for a 0..w-1 bit index; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_word_tx_counter.sv
// Bit-position counter for the serializer. It counts 0..W-1, saturates
// at W-1 and flags the last bit position.
module ser_bit_counter
    import serial_word_tx_pkg::*;
#(
    parameter int W = W_DEF,
    localparam int CW = cnt_width(W)
) (
    input  logic          t_clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          is_last
);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    logic [CW-1:0] cnt_r;
    logic          is_last_s;

    // Clear has priority over enable; increment stops at the last position.
    always_ff @(posedge t_clk) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
        end else if (clr) begin
            cnt_r <= CNT_ZERO;
        end else if (en && !is_last_s) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Last-position decode.
    always_comb begin
        is_last_s = (cnt_r == CNT_LAST);
    end

    assign cnt     = cnt_r;
    assign is_last = is_last_s;

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter, LSB first, with a word-start strobe
// and back-to-back acceptance on the last bit of the current word.
module serial_word_tx
    import serial_word_tx_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         t_clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         ser_bit,
    output logic         ser_start,
    output logic         ser_valid,
    output logic         busy
);

    localparam int CW = cnt_width(W);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    logic [0:0]    state_r;
    logic [W-1:0]  shift_r;
    logic [CW-1:0] cnt_s;
    logic          is_last_s;
    logic          in_shift_s;
    logic          in_ready_s;
    logic          xfer_s;
    logic          cnt_clr_s;
    logic          cnt_en_s;

    ser_bit_counter #(
        .W (W)
    ) u_cnt (
        .t_clk   (t_clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr_s),
        .en      (cnt_en_s),
        .cnt     (cnt_s),
        .is_last (is_last_s)
    );

    // Ready depends only on state and counter, never on in_valid.
    always_comb begin
        in_shift_s = (state_r == ST_SHIFT);
        case (state_r)
            ST_IDLE:  in_ready_s = 1'b1;
            ST_SHIFT: in_ready_s = is_last_s;
            default:  in_ready_s = 1'b0;
        endcase
        xfer_s    = in_valid & in_ready_s;
        cnt_clr_s = xfer_s | (in_shift_s & is_last_s);
        cnt_en_s  = in_shift_s & ~is_last_s;
    end

    // FSM and shift register; a new word on the last bit reloads without a gap.
    always_ff @(posedge t_clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            shift_r <= {W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (xfer_s) begin
                        state_r <= ST_SHIFT;
                        shift_r <= in_data;
                    end else begin
                        state_r <= ST_IDLE;
                        shift_r <= shift_r;
                    end
                end
                ST_SHIFT: begin
                    if (xfer_s) begin
                        state_r <= ST_SHIFT;
                        shift_r <= in_data;
                    end else if (is_last_s) begin
                        state_r <= ST_IDLE;
                        shift_r <= {1'b0, shift_r[W-1:1]};
                    end else begin
                        state_r <= ST_SHIFT;
                        shift_r <= {1'b0, shift_r[W-1:1]};
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    shift_r <= {W{1'b0}};
                end
            endcase
        end
    end

    // Serial outputs decode from state, counter and shift register only.
    always_comb begin
        if (in_shift_s) begin
            ser_bit   = shift_r[0];
            ser_valid = 1'b1;
            busy      = 1'b1;
            ser_start = (cnt_s == CNT_ZERO);
        end else begin
            ser_bit   = 1'b0;
            ser_valid = 1'b0;
            busy      = 1'b0;
            ser_start = 1'b0;
        end
    end

    assign in_ready = in_ready_s;

endmodule

// File: doc/serial_word_tx.md
SERIAL_WORD_TX -- requirements
Module: serial_word_tx

Interface
REQ-001 Parameter W, default 8: word width in bits; legal range 2..32.
REQ-002 t_clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low, sampled on the rising edge of t_clk.
REQ-004 in_valid  input  1  a parallel word is offered on in_data.
REQ-005 in_data  input  W  word to serialize, in two's-complement or unsigned form; bit 0 is sent first.
REQ-006 in_ready  output  1  block accepts in_data this cycle; the word transfers when in_valid and in_ready are both 1 at a rising edge.
REQ-007 ser_bit  output  1  serial data bit, LSB first; drives the downstream serial complementer's data input.
REQ-008 ser_start  output  1  high only during bit 0 of each word; drives the downstream complementer's word-start (r) input.
REQ-009 ser_valid  output  1  ser_bit carries a live word bit this cycle.
REQ-010 busy  output  1  a word is being shifted out.

Function
REQ-011 FSM states: IDLE and SHIFT only.
REQ-012 IDLE: in_ready=1, ser_valid=0, ser_start=0, ser_bit=0, busy=0.
REQ-013 IDLE with a transfer: load in_data into the shift register, clear the bit counter, go to SHIFT; bit 0 appears on the cycle after the transfer edge (latency 1).
REQ-014 SHIFT: ser_bit = shift_reg[0]; ser_valid=1; busy=1; ser_start=1 exactly when the counter is 0.
REQ-015 Each rising edge in SHIFT shifts the register right by one and increments the counter; bit k of the word is output k+1 cycles after the transfer edge, for k = 0..W-1.
REQ-016 in_ready=0 in SHIFT except on the last bit (counter = W-1), where in_ready=1.
REQ-017 Last bit with a transfer: load the new word and clear the counter; stay in SHIFT. The next word's bit 0 follows with no gap cycle, and ser_start pulses again.
REQ-018 Last bit with no transfer: go to IDLE. ser_valid drops on the following cycle.
REQ-019 in_data and in_valid are ignored whenever in_ready=0. A held word is sampled only on its transfer edge.
REQ-020 Counter width is clog2(W). The counter never exceeds W-1 and never wraps silently.
REQ-021 All outputs are registered or decoded only from state, counter and shift register. No combinational path from in_valid or in_data to any output except in_ready, which depends on state and counter only.

Reset
REQ-022 rst_n=0 at an edge: state=IDLE, counter=0, shift register=0, and all outputs take their IDLE values from the next cycle.
REQ-023 Reset mid-word aborts the word without finishing it. No partial bits are emitted after the reset edge, and ser_start is not asserted until a new transfer.
REQ-024 Reset takes priority over a simultaneous transfer; that word is dropped.

Structure
REQ-025 A shared package holds the state enum (IDLE, SHIFT) and the default width constant W_DEF=8.
REQ-026 One sub-module, ser_bit_counter, is natural. It is a 0..W-1 counter with clear, enable and an is_last flag.
REQ-027 The target size is 120-400 RTL lines with no memories and no second clock.

Verification
REQ-028 Single word: W=8, transfer 0xB5 from IDLE.
- ser_bit over 8 consecutive cycles = 1,0,1,0,1,1,0,1.
- ser_start high only on the first of those cycles.
- ser_valid high for exactly 8 cycles, then IDLE.
REQ-029 Back-to-back: 0x01, then 0x80 offered and accepted on 0x01's last bit.
- 16 contiguous ser_valid cycles.
- Bit stream 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1.
- ser_start pulses on cycles 1 and 9.
REQ-030 Backpressure: in_valid held at 1 with in_data changing during SHIFT.
- in_ready=0 on bits 0..6.
- Only the value present on the bit-7 edge is transferred.
REQ-031 Reset mid-word: rst_n=0 during bit 3 of 0xFF.
- Next cycle: ser_valid=0, ser_bit=0, busy=0, in_ready=1.
- A following transfer of 0x0F serializes correctly.
REQ-032 Chain check: serial_word_tx feeds the serial two's complementer, with 0x06 sent.
- Complementer output over the word = 0,1,0,1,1,1,1,1 (0xFA, LSB first).
REQ-033 Boundary width: W=2, transfers 2'b10 then 2'b01 back-to-back.
- Stream 0,1,1,0.
- ser_start on cycles 1 and 3.
